// File: rtl/muldiv_if.sv
// Execute-stage port bundle for the multi-cycle MUL/MOD unit.
// The pipeline side drives the operation request; the unit answers with
// stall/busy/done and the result. dbg_state mirrors the unit's FSM state.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;
    logic [1:0]       dbg_state;

    modport master (
        output start, alu_ctrl, op_a, op_b, flush,
        input  stall, busy, done, result, div_by_zero, dbg_state
    );

    modport slave (
        input  start, alu_ctrl, op_a, op_b, flush,
        output stall, busy, done, result, div_by_zero, dbg_state
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MUL (shift-add) / MOD (restoring division) engine beside the ALU.
//
// Handshake: start is the request valid; the unit is ready only in IDLE with
// no flush. A request is taken (accept) on a rising edge where start is high,
// alu_ctrl names MUL or MOD, the FSM is IDLE and flush is low. stall is high
// from the accept cycle until the cycle before done, so the pipeline holds the
// instruction and its operands; done pulses for one cycle with result valid,
// and stall is low in that cycle so the pipeline advances on the same edge.
module muldiv_sequencer #(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_MUL = 2'd1,
        RUN_MOD = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_MOD = 4'b0011;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;       // multiplicand (MUL) or dividend (MOD), shifted left
    logic [WIDTH-1:0] b_q;       // multiplier (MUL, shifted right) or divisor (MOD)
    logic [WIDTH-1:0] acc_q;     // product accumulator or partial remainder
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic             is_op;
    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;

    assign is_op     = (bus.alu_ctrl == OP_MUL) | (bus.alu_ctrl == OP_MOD);
    assign accept    = bus.start & is_op & (state == IDLE) & ~bus.flush;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // One iteration step: add-if-set for MUL, shift/compare/subtract for MOD.
    // The shifted remainder needs WIDTH+1 bits, but after a successful compare
    // the difference is below the divisor, so WIDTH bits of it are exact.
    always_comb begin
        rem_sh  = {acc_q, a_q[WIDTH-1]};
        rem_sub = rem_sh[WIDTH-1:0] - b_q;
        acc_nxt = acc_q;
        if (state == RUN_MUL) begin
            if (b_q[0]) acc_nxt = acc_q + a_q;
        end else if (state == RUN_MOD) begin
            if (rem_sh >= {1'b0, b_q}) acc_nxt = rem_sub;
            else                       acc_nxt = rem_sh[WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: flush aborts a running operation but never a finished one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.alu_ctrl == OP_MUL)      state_nxt = RUN_MUL;
                    else if (bus.op_b == '0)         state_nxt = DONE;
                    else                             state_nxt = RUN_MOD;
                end
            end
            RUN_MUL, RUN_MOD: begin
                if (bus.flush)      state_nxt = IDLE;
                else if (last_iter) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result/status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_nxt == RUN_MUL) | (state_nxt == RUN_MOD);
            done_q <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= bus.op_a;
                        b_q   <= bus.op_b;
                        acc_q <= '0;
                        cnt_q <= '0;
                        dbz_q <= 1'b0;
                        if ((bus.alu_ctrl == OP_MOD) && (bus.op_b == '0)) begin
                            result_q <= bus.op_a;
                            dbz_q    <= 1'b1;
                        end
                    end
                end
                RUN_MUL, RUN_MOD: begin
                    if (!bus.flush) begin
                        cnt_q <= cnt_q + 1'b1;
                        acc_q <= acc_nxt;
                        a_q   <= a_q << 1;
                        if (state == RUN_MUL) b_q <= b_q >> 1;
                        if (last_iter) result_q <= acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall       = busy_q | accept;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed cases plus random MUL/MOD traffic,
// checked against a plain-arithmetic model (a*b mod 2^W, a%b, a for b==0).
module tb_muldiv_sequencer;
    localparam int W = 32;
    localparam logic [3:0] C_MUL = 4'b0010;
    localparam logic [3:0] C_MOD = 4'b0011;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_result;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from a negedge and follow it to its done cycle.
    // Returns at the negedge of the done cycle.
    task automatic run_op(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        logic [W-1:0]   exp_r;
        logic [W-1:0]   got_r;
        logic           exp_z;
        int             exp_lat;
        int             cyc;
        logic           got_done;
        if (ctrl == C_MUL) begin
            prod    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            exp_r   = prod[W-1:0];
            exp_z   = 1'b0;
            exp_lat = W + 1;
        end else if (b == '0) begin
            exp_r   = a;
            exp_z   = 1'b1;
            exp_lat = 1;
        end else begin
            exp_r   = a % b;
            exp_z   = 1'b0;
            exp_lat = W + 1;
        end
        exp_q.push_back(exp_r);
        bus.start = 1'b1; bus.alu_ctrl = ctrl; bus.op_a = a; bus.op_b = b;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            failures++; $display("FAIL stall_on_accept: stall=%b expected 1", bus.stall);
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom;
        cyc = 1; got_done = 1'b0;
        while (!got_done && cyc < 4 * W) begin
            @(negedge clk);
            if (bus.done === 1'b1) got_done = 1'b1;
            else begin
                checks++;
                if (bus.stall !== 1'b1) begin
                    failures++; $display("FAIL stall_hold: cycle %0d stall=%b expected 1", cyc, bus.stall);
                end
                cyc++;
            end
        end
        got_r = exp_q.pop_front();
        checks++;
        if (!got_done) begin
            failures++; $display("FAIL done_timeout: no done within %0d cycles", 4 * W);
        end
        checks++;
        if (cyc !== exp_lat) begin
            failures++; $display("FAIL latency: stall cycles=%0d expected %0d", cyc, exp_lat);
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++; $display("FAIL stall_in_done: stall=%b expected 0", bus.stall);
        end
        checks++;
        if (bus.result !== got_r) begin
            failures++; $display("FAIL result: ctrl=%b a=%h b=%h got %h expected %h", ctrl, a, b, bus.result, got_r);
        end
        checks++;
        if (bus.div_by_zero !== exp_z) begin
            failures++; $display("FAIL div_by_zero: got %b expected %b", bus.div_by_zero, exp_z);
        end
        last_result = got_r;
    endtask

    // Step past the done cycle and confirm the pulse lasted one cycle.
    task automatic idle_step();
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            failures++; $display("FAIL done_pulse_width: done=%b expected 0", bus.done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.alu_ctrl = 4'b0000; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.stall} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: busy/done/dbz/stall=%b expected 0000",
                                 {bus.busy, bus.done, bus.div_by_zero, bus.stall});
        end
        checks++;
        if (bus.result !== '0) begin
            failures++; $display("FAIL reset_result: got %h expected 0", bus.result);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        run_op(C_MUL, 32'd7, 32'd6);
        idle_step();
        run_op(C_MUL, 32'hFFFF_FFFF, 32'd2);
        idle_step();
    endtask

    task automatic test_mod();
        run_op(C_MOD, 32'd100, 32'd7);
        idle_step();
        run_op(C_MOD, 32'd5, 32'd9);
        idle_step();
        run_op(C_MOD, 32'd123, 32'd0);
        idle_step();
        run_op(C_MOD, 32'd10, 32'd3);
        idle_step();
    endtask

    task automatic test_reset_mid();
        logic seen;
        bus.start = 1'b1; bus.alu_ctrl = C_MUL; bus.op_a = 32'd7; bus.op_b = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL mid_busy: busy=%b expected 1", bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.stall} !== 3'b000) begin
            failures++; $display("FAIL async_reset_flags: busy/done/stall=%b expected 000",
                                 {bus.busy, bus.done, bus.stall});
        end
        checks++;
        if (bus.result !== '0) begin
            failures++; $display("FAIL async_reset_result: got %h expected 0", bus.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (2 * W) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL reset_discard: done/busy seen after reset, expected none");
        end
        last_result = '0;
    endtask

    task automatic test_flush();
        logic seen;
        // Flush at iteration 10 of a MUL.
        run_op(C_MUL, 32'd1234, 32'd5678);
        idle_step();
        bus.start = 1'b1; bus.alu_ctrl = C_MUL; bus.op_a = 32'd99; bus.op_b = 32'd77;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.stall, bus.done} !== 3'b000) begin
            failures++; $display("FAIL flush_run: busy/stall/done=%b expected 000", {bus.busy, bus.stall, bus.done});
        end
        checks++;
        if (bus.result !== last_result) begin
            failures++; $display("FAIL flush_result: got %h expected %h", bus.result, last_result);
        end
        seen = 1'b0;
        repeat (2 * W) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL flush_no_done: done pulse after flush");
        end
        // Flush coinciding with the final iteration.
        bus.start = 1'b1; bus.alu_ctrl = C_MOD; bus.op_a = 32'd1000; bus.op_b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (W) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL flush_last_busy: busy=%b expected 1", bus.busy);
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            failures++; $display("FAIL flush_last: done/busy=%b expected 00", {bus.done, bus.busy});
        end
        checks++;
        if (bus.result !== last_result) begin
            failures++; $display("FAIL flush_last_result: got %h expected %h", bus.result, last_result);
        end
        // Flush in IDLE blocks the accept.
        bus.start = 1'b1; bus.alu_ctrl = C_MUL; bus.op_a = 32'd3; bus.op_b = 32'd4; bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++; $display("FAIL flush_idle_stall: stall=%b expected 0", bus.stall);
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL flush_idle_busy: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_illegal();
        for (int c = 0; c < 16; c++) begin
            if (c != 2 && c != 3) begin
                bus.start = 1'b1; bus.alu_ctrl = 4'(c); bus.op_a = $urandom; bus.op_b = $urandom;
                #1;
                checks++;
                if (bus.stall !== 1'b0) begin
                    failures++; $display("FAIL illegal_stall: ctrl=%0d stall=%b expected 0", c, bus.stall);
                end
                @(negedge clk);
                checks++;
                if ({bus.busy, bus.done} !== 2'b00) begin
                    failures++; $display("FAIL illegal_busy: ctrl=%0d busy/done=%b expected 00", c, {bus.busy, bus.done});
                end
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 12; i++) begin
            ctrl = ($urandom_range(0, 1) == 0) ? C_MUL : C_MOD;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(ctrl, a, b);
            idle_step();
        end
    endtask

    task automatic test_back_to_back();
        run_op(C_MUL, 32'd12345, 32'd6789);
        // Request presented during DONE must wait for IDLE.
        bus.start = 1'b1; bus.alu_ctrl = C_MOD; bus.op_a = 32'd987654; bus.op_b = 32'd321;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++; $display("FAIL b2b_done_stall: stall=%b expected 0", bus.stall);
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            failures++; $display("FAIL b2b_not_taken: busy/done=%b expected 00", {bus.busy, bus.done});
        end
        run_op(C_MOD, 32'd987654, 32'd321);
        idle_step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        last_result = '0;
        test_reset();
        test_mul();
        test_mod();
        test_reset_mid();
        test_flush();
        test_illegal();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
